// File: rtl/spm_pkg.sv
// Shared definitions for the single-port-memory round-robin arbiter.
//   REQ_A / REQ_B    : encoding used for the read owner and last-grant state
//   DEF_DATA_WIDTH   : default data word width
//   DEF_ADDR_WIDTH   : default memory address width
package spm_pkg;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 8;

endpackage

// File: rtl/spm_rr_arbiter_rr_pick.sv
// Two-way round-robin select, purely combinational.
//   i_req_a / i_req_b : pending requests
//   i_last            : requester granted most recently (REQ_A / REQ_B)
//   o_gnt_a / o_gnt_b : one-hot (or all-zero) grant
// On contention the requester that did not win last time is chosen.
module rr_pick
  import spm_pkg::*;
(
  input  logic i_req_a,
  input  logic i_req_b,
  input  logic i_last,
  output logic o_gnt_a,
  output logic o_gnt_b
);

  logic w_a_wins;

  // A wins a tie only when B was the previous winner.
  assign w_a_wins = i_req_a & (~i_req_b | (i_last == REQ_B));

  assign o_gnt_a = w_a_wins;
  assign o_gnt_b = i_req_b & ~w_a_wins;

endmodule

// File: rtl/spm_rr_arbiter.sv
// Round-robin arbiter sharing one single-port memory between requesters A and B.
// At most one access (read or write) is issued per cycle; read data returns to
// its owner with a one-cycle rvalid pulse the cycle after issue.
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_x_req/i_x_wr/i_x_addr/i_x_wdata  requester x transaction (x = a, b)
//   o_x_gnt                        transaction accepted this cycle
//   o_x_rvalid/o_x_rdata           read return (rdata is 0 when not valid)
//   o_mem_wr_en/o_mem_rd_en/o_mem_address/o_mem_wr_data  memory command
//   i_mem_rd_data                  memory read data (meaningful only when a read is pending)
module spm_rr_arbiter
  import spm_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_a_req,
  input  logic                  i_a_wr,
  input  logic [ADDR_WIDTH-1:0] i_a_addr,
  input  logic [DATA_WIDTH-1:0] i_a_wdata,
  output logic                  o_a_gnt,
  output logic                  o_a_rvalid,
  output logic [DATA_WIDTH-1:0] o_a_rdata,
  input  logic                  i_b_req,
  input  logic                  i_b_wr,
  input  logic [ADDR_WIDTH-1:0] i_b_addr,
  input  logic [DATA_WIDTH-1:0] i_b_wdata,
  output logic                  o_b_gnt,
  output logic                  o_b_rvalid,
  output logic [DATA_WIDTH-1:0] o_b_rdata,
  output logic                  o_mem_wr_en,
  output logic                  o_mem_rd_en,
  output logic [ADDR_WIDTH-1:0] o_mem_address,
  output logic [DATA_WIDTH-1:0] o_mem_wr_data,
  input  logic [DATA_WIDTH-1:0] i_mem_rd_data
);

  logic r_last_grant;
  logic r_rd_pend;
  logic r_rd_owner;

  logic w_pick_a;
  logic w_pick_b;
  logic w_gnt_a;
  logic w_gnt_b;
  logic w_any_gnt;
  logic w_sel;

  rr_pick u_rr_pick (
    .i_req_a (i_a_req),
    .i_req_b (i_b_req),
    .i_last  (r_last_grant),
    .o_gnt_a (w_pick_a),
    .o_gnt_b (w_pick_b)
  );

  // Grants are gated by reset so nothing is issued (and no read is queued)
  // while reset is held.
  assign w_gnt_a   = w_pick_a & i_rst_n;
  assign w_gnt_b   = w_pick_b & i_rst_n;
  assign w_any_gnt = w_gnt_a | w_gnt_b;
  assign w_sel     = w_gnt_b ? REQ_B : REQ_A;

  assign o_a_gnt = w_gnt_a;
  assign o_b_gnt = w_gnt_b;

  always_comb begin
    o_mem_wr_en   = 1'b0;
    o_mem_rd_en   = 1'b0;
    o_mem_address = '0;
    o_mem_wr_data = '0;
    if (w_gnt_a) begin
      o_mem_wr_en   = i_a_wr;
      o_mem_rd_en   = ~i_a_wr;
      o_mem_address = i_a_addr;
      o_mem_wr_data = i_a_wdata;
    end else if (w_gnt_b) begin
      o_mem_wr_en   = i_b_wr;
      o_mem_rd_en   = ~i_b_wr;
      o_mem_address = i_b_addr;
      o_mem_wr_data = i_b_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_grant <= REQ_B;
      r_rd_pend    <= 1'b0;
      r_rd_owner   <= REQ_A;
    end else begin
      if (w_any_gnt) begin
        r_last_grant <= w_sel;
      end
      // A new read every cycle keeps rd_pend high for back-to-back returns.
      r_rd_pend <= o_mem_rd_en;
      if (o_mem_rd_en) begin
        r_rd_owner <= w_sel;
      end
    end
  end

  assign o_a_rvalid = r_rd_pend & (r_rd_owner == REQ_A);
  assign o_b_rvalid = r_rd_pend & (r_rd_owner == REQ_B);

  // Memory data is undefined outside a pending read; never let it escape.
  assign o_a_rdata = o_a_rvalid ? i_mem_rd_data : '0;
  assign o_b_rdata = o_b_rvalid ? i_mem_rd_data : '0;

endmodule

// File: tb/tb_spm_rr_arbiter.sv
module tb_spm_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_req, a_wr, b_req, b_wr;
  logic [7:0] a_addr, a_wdata, b_addr, b_wdata;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [7:0] a_rdata, b_rdata;
  logic       mem_wr_en, mem_rd_en;
  logic [7:0] mem_address, mem_wr_data, mem_rd_data;

  always #5 clk = ~clk;

  spm_rr_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_a_req       (a_req),
    .i_a_wr        (a_wr),
    .i_a_addr      (a_addr),
    .i_a_wdata     (a_wdata),
    .o_a_gnt       (a_gnt),
    .o_a_rvalid    (a_rvalid),
    .o_a_rdata     (a_rdata),
    .i_b_req       (b_req),
    .i_b_wr        (b_wr),
    .i_b_addr      (b_addr),
    .i_b_wdata     (b_wdata),
    .o_b_gnt       (b_gnt),
    .o_b_rvalid    (b_rvalid),
    .o_b_rdata     (b_rdata),
    .o_mem_wr_en   (mem_wr_en),
    .o_mem_rd_en   (mem_rd_en),
    .o_mem_address (mem_address),
    .o_mem_wr_data (mem_wr_data),
    .i_mem_rd_data (mem_rd_data)
  );

  // Single-port memory model: write commits at the issue edge, read data is
  // registered and undefined in cycles without a read.
  logic [7:0] mem [0:255];
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_address] <= mem_wr_data;
    if (mem_rd_en) mem_rd_data <= mem[mem_address];
    else           mem_rd_data <= 'x;
  end

  typedef struct packed {
    logic       owner;
    logic [7:0] data;
  } rsp_t;

  rsp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Response monitor: every rvalid pulse must match the oldest expected read.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (a_rvalid === 1'b1 || b_rvalid === 1'b1) begin
        if (a_rvalid && b_rvalid) chk("dual_rvalid", 32'd1, 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_rvalid", {30'd0, b_rvalid, a_rvalid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_owner", {31'd0, b_rvalid}, {31'd0, e.owner});
          chk("rsp_data", {24'd0, (e.owner ? b_rdata : a_rdata)}, {24'd0, e.data});
        end
      end
    end
  end

  task automatic drive_a(input logic req, input logic wr, input logic [7:0] addr, input logic [7:0] wd);
    a_req = req; a_wr = wr; a_addr = addr; a_wdata = wd;
  endtask

  task automatic drive_b(input logic req, input logic wr, input logic [7:0] addr, input logic [7:0] wd);
    b_req = req; b_wr = wr; b_addr = addr; b_wdata = wd;
  endtask

  // Bit i set: B expected to win contention cycle i (A wins first after reset state B).
  logic [5:0] arb_seq_b;

  initial begin
    arb_seq_b = 6'b101010;
    rst_n = 1'b0;
    drive_a(1'b0, 1'b0, 8'h00, 8'h00);
    drive_b(1'b0, 1'b0, 8'h00, 8'h00);

    // Reset held: a request must not be granted or issued.
    @(negedge clk);
    drive_a(1'b1, 1'b0, 8'h05, 8'h00);
    #1;
    chk("rst_gnt_a", {31'd0, a_gnt}, 32'd0);
    chk("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
    drive_a(1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // 1. Idle after release.
    repeat (10) begin
      @(negedge clk); #1;
      chk("idle_outputs", {26'd0, a_gnt, b_gnt, a_rvalid, b_rvalid, mem_wr_en, mem_rd_en}, 32'd0);
    end

    // 2. A writes 0x10 <- 0xA5, then reads it back.
    @(negedge clk);
    drive_a(1'b1, 1'b1, 8'h10, 8'hA5);
    #1;
    chk("t2_wr_gnt", {30'd0, a_gnt, b_gnt}, 32'd2);
    chk("t2_wr_cmd", {14'd0, mem_wr_en, mem_rd_en, mem_address, mem_wr_data}, {14'd0, 2'b10, 8'h10, 8'hA5});
    @(negedge clk);
    drive_a(1'b1, 1'b0, 8'h10, 8'h00);
    #1;
    chk("t2_rd_gnt", {30'd0, a_gnt, b_gnt}, 32'd2);
    chk("t2_rd_en", {31'd0, mem_rd_en}, 32'd1);
    exp_q.push_back('{owner: 1'b0, data: 8'hA5});
    @(negedge clk);
    drive_a(1'b0, 1'b0, 8'h00, 8'h00);

    // 3. Seed two addresses, then contend with reads for 6 cycles.
    @(negedge clk);
    drive_a(1'b1, 1'b1, 8'h40, 8'h11);
    @(negedge clk);
    drive_a(1'b0, 1'b0, 8'h00, 8'h00);
    drive_b(1'b1, 1'b1, 8'h41, 8'h22);
    #1;
    chk("t3_b_wr_gnt", {30'd0, a_gnt, b_gnt}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive_a(1'b1, 1'b0, 8'h40, 8'h00);
      drive_b(1'b1, 1'b0, 8'h41, 8'h00);
      #1;
      chk("t3_arb_gnt", {30'd0, a_gnt, b_gnt}, arb_seq_b[i] ? 32'd1 : 32'd2);
      if (arb_seq_b[i]) exp_q.push_back('{owner: 1'b1, data: 8'h22});
      else              exp_q.push_back('{owner: 1'b0, data: 8'h11});
    end
    @(negedge clk);
    drive_a(1'b0, 1'b0, 8'h00, 8'h00);
    drive_b(1'b0, 1'b0, 8'h00, 8'h00);

    // 4. B writes 0x20 <- 0x3C, A reads 0x20 the very next cycle.
    @(negedge clk);
    drive_b(1'b1, 1'b1, 8'h20, 8'h3C);
    @(negedge clk);
    drive_b(1'b0, 1'b0, 8'h00, 8'h00);
    drive_a(1'b1, 1'b0, 8'h20, 8'h00);
    #1;
    chk("t4_rd_gnt", {30'd0, a_gnt, b_gnt}, 32'd2);
    exp_q.push_back('{owner: 1'b0, data: 8'h3C});
    @(negedge clk);
    drive_a(1'b0, 1'b0, 8'h00, 8'h00);

    // 5. Read of 0x30 killed by reset before its return edge.
    @(negedge clk);
    drive_a(1'b1, 1'b1, 8'h30, 8'h77);
    @(negedge clk);
    drive_a(1'b1, 1'b0, 8'h30, 8'h00);
    #1;
    chk("t5_rd_gnt", {31'd0, a_gnt}, 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    drive_a(1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk); #1;
    chk("t5_drop_rvalid", {30'd0, a_rvalid, b_rvalid}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("t5_post_rvalid", {30'd0, a_rvalid, b_rvalid}, 32'd0);
    drive_a(1'b1, 1'b0, 8'h10, 8'h00);
    drive_b(1'b1, 1'b0, 8'h20, 8'h00);
    #1;
    chk("t5_first_gnt", {30'd0, a_gnt, b_gnt}, 32'd2);
    exp_q.push_back('{owner: 1'b0, data: 8'hA5});
    @(negedge clk);
    drive_a(1'b0, 1'b0, 8'h00, 8'h00);
    #1;
    chk("t5_second_gnt", {30'd0, a_gnt, b_gnt}, 32'd1);
    exp_q.push_back('{owner: 1'b1, data: 8'h3C});
    @(negedge clk);
    drive_b(1'b0, 1'b0, 8'h00, 8'h00);

    // 6. No read pending, memory output undefined: rdata must stay 0.
    repeat (4) begin
      @(negedge clk); #1;
      chk("t6_a_rdata", {24'd0, a_rdata}, 32'd0);
      chk("t6_b_rdata", {24'd0, b_rdata}, 32'd0);
    end

    repeat (2) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
